multicycle_controller: RTL



---
 rtl/multicycle_controller.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multicycle controller: Moore FSM sequencing FETCH/DECODE/EXECUTE for the
// multicycle datapath. Control outputs are decoded from the current state and
// the IR contents, so DECODE sees the freshly latched instruction.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-high reset (forces FETCH, outputs idle)
//   INSTRUCTION  IR contents from the datapath
//   FLAGS        {N,Z,C,V} from the datapath
//   A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src
//   ALUSrcA, ALUSrcB, ResultSrc, RegSrc (2 bits), ALUop, ShiftType (3 bits)
//
// Configuration macro: COND_EXEC_EN -- when defined, a failed ARM condition
// check suppresses PCWrite (BRANCH), RegWrite, MemWrite and FlagUpdate after
// DECODE. When undefined, every instruction executes unconditionally.
module multicycle_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] INSTRUCTION,
  input  logic [3:0]  FLAGS,
  output logic        A3Src,
  output logic        AdrSrc,
  output logic        FlagUpdate,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        WD3Src,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  RegSrc,
  output logic [2:0]  ALUop,
  output logic [2:0]  ShiftType
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_EXSHIFT  = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  state_t state;

  // Instruction field extraction
  logic [1:0] op;
  logic       imm;
  logic [3:0] cmd;
  logic       s_bit;
  logic       load;
  logic       link;
  logic [2:0] sh;

  assign op    = INSTRUCTION[27:26];
  assign imm   = INSTRUCTION[25];
  assign cmd   = INSTRUCTION[24:21];
  assign s_bit = INSTRUCTION[20];
  assign load  = INSTRUCTION[20];
  assign link  = INSTRUCTION[24];
  assign sh    = INSTRUCTION[7:5];

  logic is_dp, is_mem, is_br, is_cmp, is_shift, cmd_ok, illegal;
  logic [2:0] alu_op;

  assign is_dp    = (op == 2'b00);
  assign is_mem   = (op == 2'b01);
  assign is_br    = (op == 2'b10);
  assign is_cmp   = (cmd == 4'b1010);
  assign is_shift = is_dp && !imm && (cmd == 4'b1101);

  // cmd to ALU operation; unsupported commands are flagged illegal
  always_comb begin
    alu_op = 3'b000;
    cmd_ok = 1'b1;
    case (cmd)
      4'b0100: alu_op = 3'b000;
      4'b0010: alu_op = 3'b001;
      4'b0000: alu_op = 3'b010;
      4'b1100: alu_op = 3'b011;
      4'b1101: alu_op = 3'b100;
      4'b1010: alu_op = 3'b001;
      default: cmd_ok = 1'b0;
    endcase
  end

  assign illegal = (op == 2'b11) || (is_dp && !cmd_ok) || (is_shift && (sh > 3'd4));

  logic cond_ok;

`ifdef COND_EXEC_EN
  // ARM condition codes evaluated on the live flags
  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = FLAGS;

  always_comb begin
    cond_ok = 1'b1;
    case (INSTRUCTION[31:28])
      4'b0000: cond_ok = flag_z;
      4'b0001: cond_ok = !flag_z;
      4'b0010: cond_ok = flag_c;
      4'b0011: cond_ok = !flag_c;
      4'b0100: cond_ok = flag_n;
      4'b0101: cond_ok = !flag_n;
      4'b0110: cond_ok = flag_v;
      4'b0111: cond_ok = !flag_v;
      4'b1000: cond_ok = flag_c && !flag_z;
      4'b1001: cond_ok = !flag_c || flag_z;
      4'b1010: cond_ok = (flag_n == flag_v);
      4'b1011: cond_ok = (flag_n != flag_v);
      4'b1100: cond_ok = !flag_z && (flag_n == flag_v);
      4'b1101: cond_ok = flag_z || (flag_n != flag_v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
`else
  assign cond_ok = 1'b1;

  logic unused_cond;
  assign unused_cond = ^{FLAGS, INSTRUCTION[31:28]};
`endif

  logic unused_fields;
  assign unused_fields = ^{INSTRUCTION[19:8], INSTRUCTION[4:0]};

  // State register and next-state sequencing
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          if (illegal)       state <= S_FETCH;
          else if (is_mem)   state <= S_MEMADR;
          else if (is_shift) state <= S_EXSHIFT;
          else if (is_dp)    state <= imm ? S_EXECI : S_EXECR;
          else if (is_br)    state <= S_BRANCH;
          else               state <= S_FETCH;
        end
        S_MEMADR:   state <= load ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: state <= S_FETCH;
        S_EXECR:    state <= is_cmp ? S_FETCH : S_ALUWB;
        S_EXECI:    state <= is_cmp ? S_FETCH : S_ALUWB;
        S_EXSHIFT:  state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Output decode; reset forces the idle values regardless of state
  always_comb begin
    A3Src      = 1'b0;
    AdrSrc     = 1'b0;
    FlagUpdate = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    WD3Src     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    RegSrc     = 2'b00;
    ALUop      = 3'b000;
    ShiftType  = 3'b111;
    if (!reset) begin
      RegSrc = {is_mem, is_br};
      case (state)
        S_FETCH: begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          ALUSrcB   = 2'b11;
          ResultSrc = 2'b10;
          RegSrc    = 2'b10;
        end
        S_DECODE: begin
          ALUSrcB   = 2'b11;
          ResultSrc = 2'b10;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          ALUop   = 3'b000;
        end
        S_MEMREAD: AdrSrc = 1'b1;
        S_MEMWB: begin
          AdrSrc    = 1'b1;
          ResultSrc = 2'b01;
          RegWrite  = cond_ok;
        end
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = cond_ok;
        end
        S_EXECR, S_EXECI: begin
          ALUSrcA    = 2'b01;
          ALUSrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
          ALUop      = alu_op;
          // CMP always updates flags
          FlagUpdate = (s_bit || is_cmp) && cond_ok;
        end
        S_EXSHIFT: begin
          ALUSrcA   = 2'b10;
          ShiftType = sh;
        end
        S_ALUWB: begin
          ALUSrcA   = 2'b01;
          ResultSrc = 2'b00;
          RegWrite  = cond_ok;
        end
        S_BRANCH: begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          PCWrite   = cond_ok;
          // Branch-with-link writes PC+4 into R14
          RegWrite  = link && cond_ok;
          A3Src     = link;
          WD3Src    = link;
        end
        default: ;
      endcase
    end
  end

endmodule
